instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- IF stage plus IF/ID pipeline register; the stage directly upstream of instruction decode.
- Holds the PC, issues word reads to instruction memory over a req/ready handshake, and presents {PC+4, instruction} to decode.
- Obeys decode's hazard outputs (pcWrite, ifIdWrite) and redirects on taken branch/jump with IF/ID flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word injected as a bubble.

Ports:
- clk  in  1  stage clock; all state updates on the falling edge, matching the other pipeline registers.
- resetN  in  1  asynchronous, active-low reset.
- pcWrite  in  1  from hazard detection; 0 freezes the PC.
- ifIdWrite  in  1  from hazard detection; 0 freezes the IF/ID register.
- branchTaken  in  1  redirect request, resolved downstream.
- branchTarget  in  32  redirect address; bits [1:0] ignored and forced to 0.
- imemAddr  out  32  word-aligned fetch address (= PC).
- imemReq  out  1  read request.
- imemData  in  32  read data, valid when imemReady=1.
- imemReady  in  1  memory has data for the current imemAddr this cycle.
- programCounterOut  out  32  registered PC+4 of the fetched instruction.
- instruction  out  32  registered instruction word.
- instructionValid  out  1  1 = real instruction, 0 = bubble.

Behaviour:
- Reset (async, resetN=0): PC=RESET_PC, state=RUN, programCounterOut=0, instruction=NOP_WORD, instructionValid=0, pendingTarget=0. imemReq=0 while in reset; 1 otherwise.
- imemAddr is driven combinationally from PC in RUN. In DRAIN it is driven from the held stale address. imemAddr must stay stable while imemReq=1 and imemReady=0.
- Memory reads are side-effect free. A response not accepted this cycle is re-fetched later, with no buffering.
- Accept condition: accept = imemReady & pcWrite & ifIdWrite & state==RUN & !branchTaken.
- States:
  - RUN: normal fetch.
  - DRAIN: a redirect arrived while a fetch was outstanding. Hold the old address until imemReady=1, discard that data, then set PC=pendingTarget and go to RUN.
- Each falling edge in RUN, priority from highest to lowest:
  1. branchTaken=1:
     - IF/ID <= {0, NOP_WORD, valid 0}; this overrides ifIdWrite=0.
     - If imemReady=1 or no fetch is outstanding: PC <= branchTarget.
     - Otherwise: pendingTarget <= branchTarget, go to DRAIN.
  2. pcWrite=0 or ifIdWrite=0:
     - PC holds.
     - If ifIdWrite=1 (pcWrite=0 only): IF/ID <= bubble.
     - If ifIdWrite=0: IF/ID holds.
  3. accept:
     - PC <= PC+4, with wrap 32'hFFFF_FFFC -> 0.
     - IF/ID <= {PC+4, imemData, 1}.
  4. Miss (imemReady=0): PC holds, IF/ID <= bubble.
- In DRAIN:
  - IF/ID <= bubble (held if ifIdWrite=0).
  - A new branchTaken overwrites pendingTarget.
  - Exit when imemReady=1.
- Fetch latency: zero-wait memory gives one instruction per cycle and a 1-cycle fetch-to-decode latency. A taken branch costs 1 bubble in the flushed slot.
- Async reset mid-DRAIN abandons the outstanding fetch; the memory must tolerate dropped requests.
- All arithmetic is 32-bit unsigned with carry discarded.

Decomposition:
- Shared package (pipeline_pkg): NOP_WORD, RESET_PC default, fetch-state encoding {RUN, DRAIN}, and a struct/constant set for the IF/ID record {pc4, instr, valid}.
- One natural sub-module: if_id_register. It is the falling-edge IF/ID register with hold (ifIdWrite), flush (bubble insert) and async reset, and the top keeps the PC/FSM.

Test Plan:
- Reset release, zero-wait memory returning addr|0xA000_0000 -> the first falling edge outputs programCounterOut=4, instruction=0xA000_0000, valid 1; the PC then walks 4, 8, 12…
- Hold pcWrite=0 and ifIdWrite=0 for 2 cycles with PC=0x10 -> imemAddr stays 0x10 and IF/ID holds; after release, 0x10 is fetched once and no instruction is skipped.
- Assert pcWrite=0 with ifIdWrite=1 for 1 cycle -> exactly one bubble (valid 0, instruction 0) and PC unchanged.
- Assert branchTaken with branchTarget=0x0000_0103 while imemReady=1 -> next imemAddr=0x100 and one bubble, even with ifIdWrite=0.
- Use 3-wait-state memory and assert branchTaken (target 0x200) on the first wait cycle -> address holds until ready, the stale data is discarded (valid 0), then imemAddr=0x200.
- PC=0xFFFF_FFFC is accepted -> programCounterOut=0 and the next imemAddr=0. Assert resetN low mid-DRAIN -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, IF/ID record layout,
// reset/bubble constants and small address helpers.
package pipeline_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

    // RUN fetches normally; DRAIN waits out a fetch that was in flight
    // when a redirect arrived, then jumps to the pending target.
    typedef enum logic {
        FETCH_RUN   = 1'b0,
        FETCH_DRAIN = 1'b1
    } fetch_state_t;

    // IF/ID record handed to decode.
    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    // Instruction addresses are word aligned; low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Bubble record: no PC, NOP instruction, marked invalid.
    function automatic if_id_t make_bubble(input logic [31:0] nop);
        if_id_t b;
        b.pc4   = 32'h0000_0000;
        b.instr = nop;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: falling-edge capture with hold, flush to bubble
// and asynchronous active-low reset to a bubble.
module if_id_register
    import pipeline_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic   clk,
    input  logic   resetN,
    input  logic   write_en,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    // Flush wins over hold so a redirect always kills the wrong-path slot.
    always_ff @(negedge clk or negedge resetN) begin
        if (!resetN) begin
            q <= make_bubble(NOP_WORD);
        end else if (flush) begin
            q <= make_bubble(NOP_WORD);
        end else if (write_en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, RUN/DRAIN redirect FSM and the
// imem req/ready handshake, feeding the IF/ID register toward decode.
module instruction_fetch
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        pcWrite,
    input  logic        ifIdWrite,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    output logic [31:0] imemAddr,
    output logic        imemReq,
    input  logic [31:0] imemData,
    input  logic        imemReady,
    output logic [31:0] programCounterOut,
    output logic [31:0] instruction,
    output logic        instructionValid
);

    fetch_state_t state_p0, state_nxt;
    logic [31:0]  pc_p0, pc_nxt;
    logic [31:0]  pend_p0, pend_nxt;
    logic [31:0]  pc_plus4;
    logic [31:0]  redirect;
    logic         accept;
    logic         ifid_we;
    logic         ifid_flush;
    if_id_t       ifid_d;
    if_id_t       ifid_q;

    // 32-bit add: 0xFFFF_FFFC + 4 wraps to 0 by dropping the carry.
    assign pc_plus4 = pc_p0 + 32'd4;
    assign redirect = word_align(branchTarget);
    assign accept   = imemReady & pcWrite & ifIdWrite
                    & (state_p0 == FETCH_RUN) & ~branchTaken;

    // The PC is not updated while draining, so it doubles as the held
    // stale address and keeps imemAddr stable until the memory responds.
    assign imemAddr = pc_p0;
    assign imemReq  = resetN;

    // Next PC / state / IF/ID load, in redirect > stall > accept > miss order.
    always_comb begin
        state_nxt  = state_p0;
        pc_nxt     = pc_p0;
        pend_nxt   = pend_p0;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        ifid_d     = make_bubble(NOP_WORD);
        if (state_p0 == FETCH_RUN) begin
            if (branchTaken) begin
                ifid_flush = 1'b1;
                // imemReq is always high out of reset, so without a
                // response this cycle the fetch is still outstanding.
                if (imemReady) begin
                    pc_nxt = redirect;
                end else begin
                    pend_nxt  = redirect;
                    state_nxt = FETCH_DRAIN;
                end
            end else if (!pcWrite || !ifIdWrite) begin
                ifid_we = ifIdWrite;
            end else if (accept) begin
                pc_nxt       = pc_plus4;
                ifid_d.pc4   = pc_plus4;
                ifid_d.instr = imemData;
                ifid_d.valid = 1'b1;
            end
        end else begin
            ifid_we = ifIdWrite;
            if (imemReady) begin
                // Stale response is dropped; the newest redirect wins.
                pc_nxt    = branchTaken ? redirect : pend_p0;
                state_nxt = FETCH_RUN;
            end else if (branchTaken) begin
                pend_nxt = redirect;
            end
        end
    end

    // Falling-edge PC, fetch state and pending redirect target.
    always_ff @(negedge clk or negedge resetN) begin
        if (!resetN) begin
            state_p0 <= FETCH_RUN;
            pc_p0    <= RESET_PC;
            pend_p0  <= 32'h0000_0000;
        end else begin
            state_p0 <= state_nxt;
            pc_p0    <= pc_nxt;
            pend_p0  <= pend_nxt;
        end
    end

    if_id_register #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id (
        .clk      (clk),
        .resetN   (resetN),
        .write_en (ifid_we),
        .flush    (ifid_flush),
        .d        (ifid_d),
        .q        (ifid_q)
    );

    assign programCounterOut = ifid_q.pc4;
    assign instruction       = ifid_q.instr;
    assign instructionValid  = ifid_q.valid;

endmodule
